// File: rtl/idma_pkg.sv
// -----------------------------------------------------------------------------
// idma_pkg
// Shared types for the iDMA error-handling policy controller.
//   eh_policy_e      : per-error-type policy (CONTINUE / ABORT / SOFTWARE).
//                      CONTINUE and ABORT double as the decision values that
//                      are sent to the error handler.
//   default_*_t      : default response, error-handling request and address
//                      types used when the controller is not given its own.
//   eh_state_e       : controller state.
// -----------------------------------------------------------------------------
package idma_pkg;

  typedef enum logic [1:0] {
    CONTINUE = 2'd0,
    ABORT    = 2'd1,
    SOFTWARE = 2'd2
  } eh_policy_e;

  typedef logic [31:0] default_addr_t;

  // Decision to the error handler: 0 = CONTINUE, 1 = ABORT.
  typedef logic [0:0] default_eh_req_t;

  // 1D response as seen by the error handler and the frontend.
  typedef struct packed {
    logic [7:0]    tag;
    logic          error;
    logic [1:0]    cause;
    logic          err_type;    // 0 read, 1 write
    default_addr_t burst_addr;
  } default_rsp_t;

  typedef enum logic [1:0] {
    ST_PASS,
    ST_FWD_ERR,
    ST_WAIT_SW,
    ST_ISSUE
  } eh_state_e;

  // Policy encodings 2 and 3 both hand the decision to software.
  function automatic logic policy_is_sw(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/idma_eh_policy_ctrl.sv
// -----------------------------------------------------------------------------
// idma_eh_policy_ctrl
// Sits between the iDMA error handler and the frontend. Error-free responses
// pass straight through. An error response is captured, forwarded to the
// frontend once, and then a CONTINUE/ABORT decision is sent back to the error
// handler according to the configured policy for the error type (read/write):
// fixed CONTINUE, fixed ABORT, or a software decision with optional timeout
// (timeout forces ABORT).
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   rsp_i/rsp_valid_i/rsp_ready_o     responses from the error handler
//   rsp_o/rsp_valid_o/rsp_ready_i     responses to the frontend
//   eh_o/eh_valid_o/eh_ready_i        decision to the error handler
//   sw_eh_i/sw_eh_valid_i/sw_eh_ready_o  software decision
//   cfg_rd_mode_i, cfg_wr_mode_i      policy per error type
//   cfg_timeout_i                     software wait in cycles, 0 = forever
//   err_cnt_clr_i                     clear the error counter
//   err_cnt_o                         saturating error count
//   last_addr_o/last_cause_o/last_type_o  details of the last captured error
//   timeout_o                         last software decision timed out
//   err_irq_o                         one-cycle pulse after each capture
//   busy_o                            an error is being handled
// -----------------------------------------------------------------------------
module idma_eh_policy_ctrl
  import idma_pkg::*;
#(
  parameter int unsigned ErrCntWidth   = 16,
  parameter int unsigned TimeoutWidth  = 16,
  parameter type         idma_rsp_t    = default_rsp_t,
  parameter type         idma_eh_req_t = default_eh_req_t,
  parameter type         addr_t        = default_addr_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  idma_rsp_t               rsp_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,

  output idma_rsp_t               rsp_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,

  output idma_eh_req_t            eh_o,
  output logic                    eh_valid_o,
  input  logic                    eh_ready_i,

  input  idma_eh_req_t            sw_eh_i,
  input  logic                    sw_eh_valid_i,
  output logic                    sw_eh_ready_o,

  input  logic [1:0]              cfg_rd_mode_i,
  input  logic [1:0]              cfg_wr_mode_i,
  input  logic [TimeoutWidth-1:0] cfg_timeout_i,
  input  logic                    err_cnt_clr_i,

  output logic [ErrCntWidth-1:0]  err_cnt_o,
  output addr_t                   last_addr_o,
  output logic [1:0]              last_cause_o,
  output logic                    last_type_o,
  output logic                    timeout_o,
  output logic                    err_irq_o,
  output logic                    busy_o
);

  eh_state_e               r_state,   w_state;
  idma_rsp_t               r_rsp;
  idma_eh_req_t            r_eh,      w_eh;
  logic [TimeoutWidth-1:0] r_timer,   w_timer;
  logic                    r_timeout, w_timeout;
  logic [ErrCntWidth-1:0]  r_err_cnt, w_err_cnt;
  logic                    r_irq;
  addr_t                   r_last_addr;
  logic [1:0]              r_last_cause;
  logic                    r_last_type;
  logic                    w_capture;
  logic [1:0]              w_policy;

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_state     = r_state;
    w_eh        = r_eh;
    w_timer     = r_timer;
    w_timeout   = r_timeout;
    w_capture   = 1'b0;
    rsp_o       = rsp_i;
    rsp_valid_o = rsp_valid_i;
    rsp_ready_o = rsp_ready_i;
    // The captured error type selects which policy applies.
    w_policy    = r_last_type ? cfg_wr_mode_i : cfg_rd_mode_i;

    unique case (r_state)
      ST_PASS: begin
        if (rsp_valid_i && rsp_i.error) begin
          // Swallow the error here; it is replayed from r_rsp next state.
          rsp_valid_o = 1'b0;
          rsp_ready_o = 1'b1;
          w_capture   = 1'b1;
          w_state     = ST_FWD_ERR;
        end
      end

      ST_FWD_ERR: begin
        rsp_o       = r_rsp;
        rsp_valid_o = 1'b1;
        rsp_ready_o = 1'b0;
        if (rsp_ready_i) begin
          // Policy is frozen here; later config changes do not apply.
          if (policy_is_sw(w_policy)) begin
            w_timer = '0;
            w_state = ST_WAIT_SW;
          end else begin
            w_eh    = w_policy[0] ? idma_eh_req_t'(ABORT) : idma_eh_req_t'(CONTINUE);
            w_state = ST_ISSUE;
          end
        end
      end

      ST_WAIT_SW: begin
        rsp_valid_o = 1'b0;
        rsp_ready_o = 1'b0;
        if (sw_eh_valid_i) begin
          // A software answer in the expiry cycle still wins.
          w_eh      = sw_eh_i;
          w_timeout = 1'b0;
          w_state   = ST_ISSUE;
        end else if (cfg_timeout_i != '0) begin
          if (r_timer == cfg_timeout_i - TimeoutWidth'(1)) begin
            w_eh      = idma_eh_req_t'(ABORT);
            w_timeout = 1'b1;
            w_state   = ST_ISSUE;
          end else begin
            w_timer = r_timer + TimeoutWidth'(1);
          end
        end
      end

      ST_ISSUE: begin
        rsp_valid_o = 1'b0;
        rsp_ready_o = 1'b0;
        if (eh_ready_i) w_state = ST_PASS;
      end

      default: w_state = ST_PASS;
    endcase

    // A clear coinciding with a new error still counts that error.
    w_err_cnt = r_err_cnt;
    if (w_capture) begin
      if (err_cnt_clr_i)    w_err_cnt = ErrCntWidth'(1);
      else if (~&r_err_cnt) w_err_cnt = r_err_cnt + ErrCntWidth'(1);
    end else if (err_cnt_clr_i) begin
      w_err_cnt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_PASS;
      r_timer      <= '0;
      r_timeout    <= 1'b0;
      r_err_cnt    <= '0;
      r_irq        <= 1'b0;
      r_last_addr  <= '0;
      r_last_cause <= '0;
      r_last_type  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_timeout <= w_timeout;
      r_err_cnt <= w_err_cnt;
      r_irq     <= w_capture;
      if (w_capture) begin
        r_last_addr  <= rsp_i.burst_addr;
        r_last_cause <= rsp_i.cause;
        r_last_type  <= rsp_i.err_type;
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while
  // qualified by a valid that is itself reset.
  always_ff @(posedge clk_i) begin
    r_eh <= w_eh;
    if (w_capture) r_rsp <= rsp_i;
  end

  assign eh_o          = r_eh;
  assign eh_valid_o    = (r_state == ST_ISSUE);
  assign sw_eh_ready_o = (r_state == ST_WAIT_SW);
  assign busy_o        = (r_state != ST_PASS);
  assign err_cnt_o     = r_err_cnt;
  assign last_addr_o   = r_last_addr;
  assign last_cause_o  = r_last_cause;
  assign last_type_o   = r_last_type;
  assign timeout_o     = r_timeout;
  assign err_irq_o     = r_irq;

endmodule

// File: tb/tb_idma_eh_policy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idma_eh_policy_ctrl
// Scoreboard bench: each issued response pushes the expected frontend response
// and, for errors, the expected decision (value, timeout flag, counter, last_*
// fields, software-wait length) computed from the policy rules. A monitor on
// the falling edge pops and compares at every handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idma_eh_policy_ctrl;
  import idma_pkg::*;

  localparam int unsigned CntW   = 2;
  localparam int unsigned ToW    = 8;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_i;
  default_rsp_t    rsp_i, rsp_o;
  logic            rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  default_eh_req_t eh_o, sw_eh_i;
  logic            eh_valid_o, eh_ready_i, sw_eh_valid_i, sw_eh_ready_o;
  logic [1:0]      cfg_rd_mode_i, cfg_wr_mode_i;
  logic [ToW-1:0]  cfg_timeout_i;
  logic            err_cnt_clr_i;
  logic [CntW-1:0] err_cnt_o;
  default_addr_t   last_addr_o;
  logic [1:0]      last_cause_o;
  logic            last_type_o, timeout_o, err_irq_o, busy_o;

  idma_eh_policy_ctrl #(
    .ErrCntWidth (CntW),
    .TimeoutWidth(ToW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rsp_i(rsp_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_o(rsp_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .eh_o(eh_o), .eh_valid_o(eh_valid_o), .eh_ready_i(eh_ready_i),
    .sw_eh_i(sw_eh_i), .sw_eh_valid_i(sw_eh_valid_i), .sw_eh_ready_o(sw_eh_ready_o),
    .cfg_rd_mode_i(cfg_rd_mode_i), .cfg_wr_mode_i(cfg_wr_mode_i),
    .cfg_timeout_i(cfg_timeout_i), .err_cnt_clr_i(err_cnt_clr_i),
    .err_cnt_o(err_cnt_o), .last_addr_o(last_addr_o), .last_cause_o(last_cause_o),
    .last_type_o(last_type_o), .timeout_o(timeout_o), .err_irq_o(err_irq_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          dec;
    logic          tout;
    int            cnt;
    default_addr_t addr;
    logic [1:0]    cause;
    logic          typ;
    int            wait_cyc;
  } eh_exp_t;

  default_rsp_t q_fwd[$];
  eh_exp_t      q_eh[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int m_cnt      = 0;
  bit m_tout     = 1'b0;
  int n_err_sent = 0;
  int n_irq      = 0;
  int sw_rdy_cyc = 0;
  bit bp_random  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (err_irq_o)     n_irq++;
    if (sw_eh_ready_o) sw_rdy_cyc++;
    if (rsp_valid_o && rsp_ready_i) begin
      if (q_fwd.size() == 0) check("fwd_unexpected", 64'(rsp_valid_o), 64'(0));
      else begin
        default_rsp_t exp_r;
        exp_r = q_fwd.pop_front();
        check("fwd_rsp", 64'(rsp_o), 64'(exp_r));
      end
    end
    if (eh_valid_o && eh_ready_i) begin
      if (q_eh.size() == 0) check("eh_unexpected", 64'(eh_valid_o), 64'(0));
      else begin
        eh_exp_t e;
        e = q_eh.pop_front();
        check("eh_decision",   64'(eh_o),         64'(e.dec));
        check("eh_timeout",    64'(timeout_o),    64'(e.tout));
        check("eh_err_cnt",    64'(err_cnt_o),    64'(e.cnt));
        check("eh_last_addr",  64'(last_addr_o),  64'(e.addr));
        check("eh_last_cause", 64'(last_cause_o), 64'(e.cause));
        check("eh_last_type",  64'(last_type_o),  64'(e.typ));
        check("eh_sw_wait",    64'(sw_rdy_cyc),   64'(e.wait_cyc));
      end
      sw_rdy_cyc = 0;
    end
  end

  // Random backpressure on both ready inputs when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_random) begin
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      eh_ready_i  = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 400) begin
      tick();
      n++;
    end
    if (busy_o) check({name, "_idle_bound"}, 64'(busy_o), 64'(0));
  endtask

  task automatic send(input default_rsp_t r, input bit clr);
    int n = 0;
    bit hs = 1'b0;
    wait_idle("send");
    rsp_i         = r;
    rsp_valid_i   = 1'b1;
    err_cnt_clr_i = clr;
    q_fwd.push_back(r);
    while (!hs && n < 400) begin
      @(negedge clk);
      hs = rsp_ready_o;
      tick();
      err_cnt_clr_i = 1'b0;
      n++;
    end
    if (!hs) check("send_bound", 64'(hs), 64'(1));
    rsp_valid_i = 1'b0;
  endtask

  function automatic default_rsp_t mk_rsp(input logic err, input logic typ,
                                          input logic [1:0] cause, input default_addr_t addr);
    default_rsp_t r;
    r.tag        = 8'($urandom);
    r.error      = err;
    r.cause      = cause;
    r.err_type   = typ;
    r.burst_addr = addr;
    return r;
  endfunction

  task automatic send_ok();
    send(mk_rsp(1'b0, 1'($urandom), 2'($urandom), $urandom), 1'b0);
  endtask

  // Issues one error and predicts its outcome. Software answers d cycles after
  // the wait starts; tmo = 0 means no timeout.
  task automatic err_txn(input logic typ, input logic [1:0] cause, input default_addr_t addr,
                         input logic [1:0] mode, input int tmo, input int d,
                         input logic sw_val, input bit clr);
    eh_exp_t e;
    int      n = 0;
    wait_idle("err_pre");
    if (typ) cfg_wr_mode_i = mode;
    else     cfg_rd_mode_i = mode;
    cfg_timeout_i = ToW'(tmo);

    n_err_sent++;
    if (clr)               m_cnt = 1;
    else if (m_cnt < CntMax) m_cnt = m_cnt + 1;
    e.cnt   = m_cnt;
    e.addr  = addr;
    e.cause = cause;
    e.typ   = typ;
    if (mode == 2'd0) begin
      e.dec = 1'(CONTINUE); e.wait_cyc = 0;
    end else if (mode == 2'd1) begin
      e.dec = 1'(ABORT);    e.wait_cyc = 0;
    end else if (tmo == 0 || d < tmo) begin
      e.dec = sw_val;       e.wait_cyc = d + 1; m_tout = 1'b0;
    end else begin
      e.dec = 1'(ABORT);    e.wait_cyc = tmo;   m_tout = 1'b1;
    end
    e.tout = m_tout;
    q_eh.push_back(e);

    send(mk_rsp(1'b1, typ, cause, addr), clr);

    while (!sw_eh_ready_o && !eh_valid_o && n < 400) begin
      tick();
      n++;
    end
    if (!sw_eh_ready_o && !eh_valid_o) check("decision_bound", 64'(busy_o), 64'(0));
    // Policy is already fixed; scrambling it must not alter the decision.
    cfg_rd_mode_i = 2'($urandom);
    cfg_wr_mode_i = 2'($urandom);
    if (sw_eh_ready_o) begin
      repeat (d) tick();
      if (sw_eh_ready_o) begin
        sw_eh_i       = sw_val;
        sw_eh_valid_i = 1'b1;
        tick();
        sw_eh_valid_i = 1'b0;
        sw_eh_i       = ~sw_val;
      end
    end
    wait_idle("err_post");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired busy=%0d", busy_o);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    default_rsp_t r;
    int n;

    rst_i = 1'b1; rsp_i = '0; rsp_valid_i = 1'b0; rsp_ready_i = 1'b1;
    eh_ready_i = 1'b1; sw_eh_i = '0; sw_eh_valid_i = 1'b0;
    cfg_rd_mode_i = 2'd0; cfg_wr_mode_i = 2'd0; cfg_timeout_i = '0; err_cnt_clr_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy",     64'(busy_o),        64'(0));
    check("rst_err_cnt",  64'(err_cnt_o),     64'(0));
    check("rst_eh_valid", 64'(eh_valid_o),    64'(0));
    check("rst_sw_ready", 64'(sw_eh_ready_o), 64'(0));
    check("rst_timeout",  64'(timeout_o),     64'(0));
    check("rst_irq",      64'(err_irq_o),     64'(0));
    check("rst_last",     64'({last_addr_o, last_cause_o, last_type_o}), 64'(0));
    tick();
    rst_i = 1'b0;
    tick();

    // Pass-through under backpressure: ready low for 3 cycles.
    rsp_ready_i = 1'b0;
    r = mk_rsp(1'b0, 1'b1, 2'd1, 32'h0000_2000);
    rsp_i = r; rsp_valid_i = 1'b1;
    q_fwd.push_back(r);
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      rsp_ready_i = (c == 3);
      @(negedge clk);
      if (rsp_valid_o) vcnt++;
      check("pt_ready_mirror", 64'(rsp_ready_o), 64'(rsp_ready_i));
      tick();
    end
    rsp_valid_i = 1'b0;
    @(negedge clk);
    check("pt_valid_cycles", 64'(vcnt),        64'(4));
    check("pt_valid_drop",   64'(rsp_valid_o), 64'(0));
    check("pt_err_cnt",      64'(err_cnt_o),   64'(0));
    tick();

    bp_random = 1'b1;
    // Read error, fixed ABORT.
    err_txn(1'b0, 2'd2, 32'h0000_1000, 2'd1, 0, 0, 1'b0, 1'b0);
    // Write error, software with no timeout, CONTINUE after 50 cycles.
    err_txn(1'b1, 2'd1, 32'h0000_3000, 2'd2, 0, 50, 1'(CONTINUE), 1'b0);
    // Write error, software, timeout 8, software never answers.
    err_txn(1'b1, 2'd3, 32'h0000_4000, 2'd2, 8, 100, 1'b0, 1'b0);
    // Software answer in the expiry cycle wins.
    err_txn(1'b0, 2'd0, 32'h0000_5000, 2'd3, 5, 4, 1'(CONTINUE), 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) send_ok();
      else err_txn(1'($urandom), 2'($urandom), $urandom, 2'($urandom),
                   3 * int'($urandom_range(0, 2)), int'($urandom_range(0, 9)),
                   1'($urandom), 1'b0);
    end

    // Clear coincident with an error capture, then a clear on its own.
    err_txn(1'b1, 2'd2, 32'h0000_6000, 2'd0, 0, 0, 1'b0, 1'b1);
    wait_idle("clr");
    @(negedge clk);
    check("cnt_before_clr", 64'(err_cnt_o), 64'(m_cnt));
    tick();
    err_cnt_clr_i = 1'b1;
    tick();
    err_cnt_clr_i = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    check("cnt_clr_alone", 64'(err_cnt_o), 64'(m_cnt));
    tick();

    // Reset while a decision is stuck in ISSUE.
    bp_random = 1'b0;
    rsp_ready_i = 1'b1;
    eh_ready_i  = 1'b0;
    wait_idle("rst_issue");
    cfg_rd_mode_i = 2'd1;
    n_err_sent++;
    send(mk_rsp(1'b1, 1'b0, 2'd3, 32'hABCD_0040), 1'b0);
    n = 0;
    while (!eh_valid_o && n < 50) begin
      tick();
      n++;
    end
    check("issue_reached", 64'(eh_valid_o), 64'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_cnt = 0; m_tout = 1'b0;
    @(negedge clk);
    check("rst_mid_eh_valid", 64'(eh_valid_o), 64'(0));
    check("rst_mid_busy",     64'(busy_o),     64'(0));
    check("rst_mid_err_cnt",  64'(err_cnt_o),  64'(m_cnt));
    check("rst_mid_last",     64'({last_addr_o, last_cause_o, last_type_o}), 64'(0));
    check("rst_mid_timeout",  64'(timeout_o),  64'(m_tout));

    repeat (4) tick();
    check("fwd_queue_drained", 64'(q_fwd.size()), 64'(0));
    check("eh_queue_drained",  64'(q_eh.size()),  64'(0));
    check("irq_pulses",        64'(n_irq),        64'(n_err_sent));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
